qbus_reg_slave: RTL and testbench

- QBUS slave cycle sequencer for the board's programmed-I/O registers.
- Sits directly upstream of the configuration-register block and the device register blocks.
- Decodes SYNC/DIN/DOUT/WTBT bus cycles into the single-cycle register interface: reg_addr, reg_bs7, reg_write, reg_wdata, reg_rdata, reg_addr_match.
- Generates RPLY and the DAL read drive. Handles DATI, DATO, DATOB and DATIO/DATIOB.

---
 rtl/qsic_pkg.sv | 25 ++
 rtl/qbus_reg_slave_if.sv | 23 ++
 rtl/qbus_reg_slave_sync_bit.sv | 28 ++
 rtl/qbus_reg_slave.sv | 127 ++++++++++++
 tb/tb_qbus_reg_slave.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/qsic_pkg.sv
// Shared definitions for the QBUS slave cycle sequencer: FSM states,
// the read-setup counter width and the DATOB byte-lane merge.
package qsic_pkg;

   localparam int unsigned DS_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      IGNORE,
      WAIT_DATA,
      READ,
      WRITE,
      RMW,
      HOLD
   } qsic_state_e;

   // hi=1 replaces the upper byte lane, hi=0 the lower one
   function automatic logic [15:0] merge_byte(input logic [15:0] cur,
                                              input logic [15:0] din,
                                              input logic        hi);
      merge_byte = hi ? {din[15:8], cur[7:0]} : {cur[15:8], din[7:0]};
   endfunction

endpackage

// File: rtl/qbus_reg_slave_if.sv
// QBUS-side signals of the register slave, as seen after the transceivers.
interface qbus_reg_slave_if;
   logic        bsync;
   logic        bdin;
   logic        bdout;
   logic        bwtbt;
   logic [21:0] adr_lat;
   logic        bs7_lat;
   logic [15:0] dal_in;
   logic        brply;
   logic [15:0] dal_out;
   logic        dal_oe;

   modport master (
      output bsync, bdin, bdout, bwtbt, adr_lat, bs7_lat, dal_in,
      input  brply, dal_out, dal_oe
   );

   modport slave (
      input  bsync, bdin, bdout, bwtbt, adr_lat, bs7_lat, dal_in,
      output brply, dal_out, dal_oe
   );
endinterface

// File: rtl/qbus_reg_slave_sync_bit.sv
// Multi-stage synchronizer for one asynchronous control input, with a
// selectable reset value.
module sync_bit #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ff <= {STAGES{RESET_VAL}};
      end else begin
         ff[0] <= d;
         for (int unsigned i = 1; i < STAGES; i++) begin
            ff[i] <= ff[i-1];
         end
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/qbus_reg_slave.sv
// QBUS slave cycle sequencer: turns SYNC/DIN/DOUT/WTBT bus cycles into a
// single-cycle register interface and generates RPLY and the DAL read drive.
module qbus_reg_slave
   import qsic_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DATA_SETUP  = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   qbus_reg_slave_if.slave        bus,
   output logic [12:0]            reg_addr,
   output logic                   reg_bs7,
   input  logic                   reg_addr_match,
   input  logic [15:0]            reg_rdata,
   output logic [15:0]            reg_wdata,
   output logic                   reg_write
);

   localparam logic [DS_W-1:0] CNT_INIT = DS_W'(DATA_SETUP - 1);

   qsic_state_e     state;
   logic [DS_W-1:0] cnt;
   logic            s_sync, s_din, s_dout, s_wtbt;
   logic            sync_q;

   // SYNC resets high so a cycle already in progress at reset release is
   // never mistaken for a fresh SYNC rise.
   sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sync (
      .clk(clk), .reset_n(reset_n), .d(bus.bsync), .q(s_sync)
   );
   sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
      .clk(clk), .reset_n(reset_n), .d(bus.bdin), .q(s_din)
   );
   sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dout (
      .clk(clk), .reset_n(reset_n), .d(bus.bdout), .q(s_dout)
   );
   sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_wtbt (
      .clk(clk), .reset_n(reset_n), .d(bus.bwtbt), .q(s_wtbt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         sync_q      <= 1'b1;
         cnt         <= '0;
         bus.brply   <= 1'b0;
         bus.dal_oe  <= 1'b0;
         bus.dal_out <= '0;
         reg_write   <= 1'b0;
         reg_wdata   <= '0;
         reg_addr    <= '0;
         reg_bs7     <= 1'b0;
      end else begin
         sync_q    <= s_sync;
         reg_write <= 1'b0;
         case (state)
            IDLE: begin
               if (s_sync) begin
                  if (sync_q) begin
                     state <= IGNORE;
                  end else begin
                     reg_addr <= bus.adr_lat[12:0];
                     reg_bs7  <= bus.bs7_lat;
                     state    <= DECODE;
                  end
               end
            end
            DECODE: state <= reg_addr_match ? WAIT_DATA : IGNORE;
            IGNORE: if (!s_sync) state <= IDLE;
            WAIT_DATA: begin
               if (!s_sync) begin
                  state <= IDLE;
               end else if (s_din && s_dout) begin
                  state <= IGNORE;
               end else if (s_din) begin
                  // read data is launched on entry so dal_oe leads brply by DATA_SETUP
                  bus.dal_out <= reg_rdata;
                  bus.dal_oe  <= 1'b1;
                  cnt         <= CNT_INIT;
                  state       <= READ;
               end else if (s_dout) begin
                  if (s_wtbt) begin
                     state <= RMW;
                  end else begin
                     reg_wdata <= bus.dal_in;
                     reg_write <= 1'b1;
                     bus.brply <= 1'b1;
                     state     <= WRITE;
                  end
               end
            end
            READ: begin
               if (!s_sync) begin
                  bus.dal_oe <= 1'b0;
                  state      <= IDLE;
               end else if (cnt == '0) begin
                  bus.brply <= 1'b1;
                  state     <= HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RMW: begin
               reg_wdata <= merge_byte(reg_rdata, bus.dal_in, reg_addr[0]);
               reg_write <= 1'b1;
               bus.brply <= 1'b1;
               state     <= WRITE;
            end
            WRITE: state <= HOLD;
            HOLD: begin
               if (!s_sync) begin
                  bus.brply  <= 1'b0;
                  bus.dal_oe <= 1'b0;
                  state      <= IDLE;
               end else if (!s_din && !s_dout) begin
                  bus.brply  <= 1'b0;
                  bus.dal_oe <= 1'b0;
                  state      <= WAIT_DATA;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qbus_reg_slave.sv
// Directed plus randomized bus cycles against qbus_reg_slave, checked
// against a word-level register model and fixed cycle latencies.
module tb_qbus_reg_slave;

   localparam int unsigned DS       = 1;
   localparam logic [21:0] BASE     = 22'o17777720;
   localparam logic [21:0] FAR      = 22'o17777600;
   localparam logic [12:0] WIN      = 13'o17720;

   logic        clk;
   logic        reset_n;
   logic [12:0] reg_addr;
   logic        reg_bs7;
   logic        reg_addr_match;
   logic [15:0] reg_rdata;
   logic [15:0] reg_wdata;
   logic        reg_write;

   qbus_reg_slave_if bus ();

   qbus_reg_slave #(.SYNC_STAGES(2), .DATA_SETUP(DS)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .reg_addr(reg_addr), .reg_bs7(reg_bs7), .reg_addr_match(reg_addr_match),
      .reg_rdata(reg_rdata), .reg_wdata(reg_wdata), .reg_write(reg_write)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // register block seen by the DUT
   logic [15:0] env_regs [4];
   logic        pre_en = 1'b0;
   logic [1:0]  pre_idx = '0;
   logic [15:0] pre_val = '0;
   // expected register contents
   logic [15:0] exp_regs [4];

   assign reg_addr_match = reg_bs7 && (reg_addr[12:3] == WIN[12:3]);
   assign reg_rdata      = env_regs[reg_addr[2:1]];

   always @(posedge clk) begin
      if (pre_en) env_regs[pre_idx] <= pre_val;
      else if (reg_write && reg_addr_match) env_regs[reg_addr[2:1]] <= reg_wdata;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [15:0] val);
      pre_idx = 2'(idx);
      pre_val = val;
      pre_en  = 1'b1;
      tick();
      pre_en  = 1'b0;
      exp_regs[idx] = val;
   endtask

   task automatic start_sync(input logic [21:0] adr);
      bus.adr_lat = adr;
      bus.bs7_lat = &adr[21:13];
      bus.bsync   = 1'b1;
      repeat (4) tick();
      check("reg_addr", 32'(reg_addr), 32'(adr[12:0]));
   endtask

   task automatic end_sync();
      bus.bsync = 1'b0;
      repeat (4) tick();
      check("idle_brply", 32'(bus.brply), 32'd0);
   endtask

   // after both strobes are low, find the first tick where the reply is gone
   task automatic release_check(input bit matched);
      int fd = -1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         if (!bus.brply && !bus.dal_oe && fd < 0) fd = t;
      end
      check("release_lat", 32'(fd), matched ? 32'd3 : 32'd1);
   endtask

   task automatic read_phase(input bit matched, input logic [15:0] exp);
      int fo = -1;
      int fr = -1;
      int nw = 0;
      logic [15:0] seen = '0;
      bus.bdin = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (bus.dal_oe && fo < 0) begin fo = t; seen = bus.dal_out; end
         if (bus.brply && fr < 0) fr = t;
         if (reg_write) nw++;
         if (fr >= 0) break;
      end
      if (matched) begin
         check("rd_oe_lat", 32'(fo), 32'd3);
         check("rd_brply_lat", 32'(fr), 32'(3 + DS));
         check("rd_data", 32'(seen), 32'(exp));
         check("rd_data_hold", 32'(bus.dal_out), 32'(exp));
      end else begin
         check("nomatch_oe", 32'(fo), 32'hFFFF_FFFF);
         check("nomatch_brply", 32'(fr), 32'hFFFF_FFFF);
      end
      check("rd_no_write", 32'(nw), 32'd0);
      bus.bdin = 1'b0;
      release_check(matched);
   endtask

   task automatic write_phase(input bit matched, input bit byte_w,
                              input logic [15:0] data, input int idx, input bit odd);
      int fr = -1;
      int nw = 0;
      int wt = -1;
      logic [15:0] wd = '0;
      logic [15:0] old = exp_regs[idx];
      logic [15:0] want;
      if (!byte_w)  want = data;
      else if (odd) want = (data & 16'hFF00) | (old & 16'h00FF);
      else          want = (old & 16'hFF00) | (data & 16'h00FF);
      bus.dal_in = data;
      bus.bwtbt  = byte_w;
      bus.bdout  = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         if (bus.brply && fr < 0) fr = t;
         if (reg_write) begin nw++; wt = t; wd = reg_wdata; end
      end
      if (matched) begin
         check("wr_brply_lat", 32'(fr), byte_w ? 32'd4 : 32'd3);
         check("wr_count", 32'(nw), 32'd1);
         check("wr_strobe_with_brply", 32'(wt), 32'(fr));
         check("wr_data", 32'(wd), 32'(want));
         exp_regs[idx] = want;
      end else begin
         check("nomatch_wr_brply", 32'(fr), 32'hFFFF_FFFF);
         check("nomatch_wr_count", 32'(nw), 32'd0);
      end
      bus.bdout = 1'b0;
      bus.bwtbt = 1'b0;
      release_check(matched);
   endtask

   initial begin
      int bad;
      reset_n     = 1'b0;
      bus.bsync   = 1'b0;
      bus.bdin    = 1'b0;
      bus.bdout   = 1'b0;
      bus.bwtbt   = 1'b0;
      bus.adr_lat = '0;
      bus.bs7_lat = 1'b0;
      bus.dal_in  = '0;
      repeat (2) tick();
      check("rst_brply", 32'(bus.brply), 32'd0);
      check("rst_dal_oe", 32'(bus.dal_oe), 32'd0);
      check("rst_dal_out", 32'(bus.dal_out), 32'd0);
      check("rst_reg_write", 32'(reg_write), 32'd0);
      check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
      check("rst_reg_addr", 32'(reg_addr), 32'd0);
      check("rst_reg_bs7", 32'(reg_bs7), 32'd0);
      for (int i = 0; i < 4; i++) preload(i, 16'($urandom));
      reset_n = 1'b1;
      repeat (6) tick();

      // DATI returning 16'o123456
      preload(0, 16'o123456);
      start_sync(BASE);
      check("reg_bs7", 32'(reg_bs7), 32'd1);
      read_phase(1'b1, 16'o123456);
      end_sync();

      // DATO 16'hBEEF
      start_sync(BASE + 22'd2);
      write_phase(1'b1, 1'b0, 16'hBEEF, 1, 1'b0);
      end_sync();

      // DATOB high byte at odd address
      preload(1, 16'h1234);
      start_sync(BASE + 22'd3);
      write_phase(1'b1, 1'b1, 16'hAA00, 1, 1'b1);
      end_sync();
      check("datob_result", 32'(exp_regs[1]), 32'h0000_AA34);

      // unmatched address, then a matched one
      start_sync(FAR);
      read_phase(1'b0, 16'h0000);
      end_sync();
      start_sync(BASE + 22'd6);
      read_phase(1'b1, exp_regs[3]);
      end_sync();

      // DATIO under one SYNC
      preload(2, 16'h0F0F);
      start_sync(BASE + 22'd4);
      read_phase(1'b1, 16'h0F0F);
      write_phase(1'b1, 1'b0, 16'h1111, 2, 1'b0);
      end_sync();

      // reset in HOLD with SYNC held high
      start_sync(BASE);
      bus.bdin = 1'b1;
      repeat (5) tick();
      check("hold_brply_pre", 32'(bus.brply), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_brply", 32'(bus.brply), 32'd0);
      check("async_rst_dal_oe", 32'(bus.dal_oe), 32'd0);
      tick();
      reset_n = 1'b1;
      bus.bdin = 1'b0;
      repeat (4) tick();
      bus.bdin = 1'b1;
      bad = 0;
      for (int t = 0; t < 10; t++) begin
         tick();
         if (bus.brply || bus.dal_oe || reg_write) bad++;
      end
      check("post_rst_ignored", 32'(bad), 32'd0);
      bus.bdin = 1'b0;
      end_sync();
      start_sync(BASE);
      read_phase(1'b1, exp_regs[0]);
      end_sync();

      // randomized cycles
      for (int n = 0; n < 24; n++) begin
         int kind = $urandom_range(0, 3);
         int idx  = $urandom_range(0, 3);
         bit odd  = 1'($urandom_range(0, 1));
         logic [15:0] d = 16'($urandom);
         case (kind)
            0: begin
               start_sync(BASE + 22'(idx * 2));
               read_phase(1'b1, exp_regs[idx]);
            end
            1: begin
               start_sync(BASE + 22'(idx * 2));
               write_phase(1'b1, 1'b0, d, idx, 1'b0);
            end
            2: begin
               start_sync(BASE + 22'(idx * 2) + 22'(odd));
               write_phase(1'b1, 1'b1, d, idx, odd);
            end
            default: begin
               start_sync(FAR + 22'(idx * 2));
               read_phase(1'b0, 16'h0000);
            end
         endcase
         end_sync();
      end

      for (int i = 0; i < 4; i++) check("final_reg", 32'(env_regs[i]), 32'(exp_regs[i]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
